// File: rtl/mac_pkg.sv
// Shared types and helpers for the PE multiply-accumulate stage.
package mac_pkg;

  // Sideband tag carried alongside the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // Widest accumulator the limit helpers can describe.
  localparam int ACC_W_MAX = 64;

  // Largest signed value representable in `width` bits (zero-extended to 64).
  function automatic logic [ACC_W_MAX-1:0] acc_max(input int width);
    acc_max = (ACC_W_MAX'(1) << (width - 1)) - ACC_W_MAX'(1);
  endfunction

  // Smallest signed value representable in `width` bits (two's complement, 64 bits).
  function automatic logic [ACC_W_MAX-1:0] acc_min(input int width);
    acc_min = ~acc_max(width);
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// Enable-gated delay line for sideband tags that must stay aligned with a
// stallable datapath pipeline. Clears on reset so no stale tag can fire.
module mac_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] data,
  output logic [W-1:0] delayed
);

  logic [W-1:0] stage [DEPTH];

  // Shift one position per advancing cycle; hold everything while en=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= data;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign delayed = stage[DEPTH-1];

endmodule

// File: rtl/mac_accumulator.sv
// Accumulator stage behind the PE multiplier: aligns valid/last tags with the
// product, builds the dot product, and parks each finished result in a
// single-entry output register for the array drain path.
//
// Output handshake: a result transfers on any rising clk edge where
// out_valid=1 and out_ready=1. While out_valid=1, out_acc/out_count/out_sat
// stay stable until that transfer. hold mirrors out_valid & ~out_ready so the
// controller can freeze pip_en before a second result collides with the first.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH_P   = 16,
  parameter int WIDTH_ACC = 32,
  parameter int LATENCY   = 6,
  parameter int CNT_W     = 8,
  parameter int SATURATE  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pip_en,
  input  logic                        in_valid,
  input  logic                        in_last,
  input  logic signed [WIDTH_P-1:0]   prod,
  output logic                        hold,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [WIDTH_ACC-1:0] out_acc,
  output logic [CNT_W-1:0]            out_count,
  output logic                        out_sat,
  output logic                        err_drop
);

  localparam int EXT_W = WIDTH_ACC + 1 - WIDTH_P;

  // Limits at sum width so the overflow compare is a plain signed compare.
  localparam logic signed [WIDTH_ACC:0] ACC_MAX = (WIDTH_ACC+1)'(acc_max(WIDTH_ACC));
  localparam logic signed [WIDTH_ACC:0] ACC_MIN = (WIDTH_ACC+1)'(acc_min(WIDTH_ACC));

  tag_t               tag_new;
  tag_t               tail;
  logic [TAG_W-1:0]   tail_bits;

  logic signed [WIDTH_ACC-1:0] acc;
  logic [CNT_W-1:0]            cnt;
  logic                        sat_run;

  logic signed [WIDTH_ACC:0]   sum_wide;
  logic signed [WIDTH_ACC-1:0] sum_res;
  logic                        ovf;
  logic [CNT_W-1:0]            cnt_inc;

  logic take;
  logic fin;
  logic accept;
  logic drop;
  logic load;

  // A last flag only means something on a valid pair.
  assign tag_new = '{valid: in_valid, last: in_last & in_valid};

  mac_tag_pipe #(
    .DEPTH (LATENCY),
    .W     (TAG_W)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pip_en),
    .data    (tag_new),
    .delayed (tail_bits)
  );

  assign tail = tag_t'(tail_bits);

  assign take   = pip_en & tail.valid;
  assign fin    = take & tail.last;
  assign accept = out_valid & out_ready;
  assign drop   = fin & out_valid & ~out_ready;
  assign load   = fin & ~drop;
  assign hold   = out_valid & ~out_ready;

  // Widened add of the aligned product, then clamp or wrap on overflow.
  always_comb begin
    sum_wide = {acc[WIDTH_ACC-1], acc} + {{EXT_W{prod[WIDTH_P-1]}}, prod};
    ovf      = (sum_wide > ACC_MAX) || (sum_wide < ACC_MIN);
    sum_res  = sum_wide[WIDTH_ACC-1:0];
    if (ovf && (SATURATE != 0)) begin
      sum_res = sum_wide[WIDTH_ACC] ? ACC_MIN[WIDTH_ACC-1:0] : ACC_MAX[WIDTH_ACC-1:0];
    end
  end

  // Term counter sticks at all-ones instead of rolling over.
  always_comb begin
    cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  end

  // Running dot product; a last term restarts it so the next term starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      cnt     <= '0;
      sat_run <= 1'b0;
    end else if (fin) begin
      acc     <= '0;
      cnt     <= '0;
      sat_run <= 1'b0;
    end else if (take) begin
      acc     <= sum_res;
      cnt     <= cnt_inc;
      sat_run <= sat_run | ovf;
    end
  end

  // Single-entry result register; a blocked register drops the newcomer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_count <= '0;
      out_sat   <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_acc   <= sum_res;
        out_count <= cnt_inc;
        out_sat   <= sat_run | ovf;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (drop) err_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator: three instances (32-bit saturating, 16-bit
// saturating, 16-bit wrapping) share one stimulus stream fed by a behavioural
// multiplier; a scoreboard queue holds the expected results.
module tb_mac_accumulator;

  localparam int WP = 16;
  localparam int L  = 6;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pip_en = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic signed [WP-1:0] prod;
  logic signed [WP-1:0] op_a = '0;
  logic signed [WP-1:0] op_b = '0;

  logic          hold_a, valid_a, sat_a, drop_a;
  logic [31:0]   acc_a;
  logic [CW-1:0] count_a;
  logic          hold_b, valid_b, sat_b, drop_b;
  logic [15:0]   acc_b;
  logic [CW-1:0] count_b;
  logic          hold_c, valid_c, sat_c, drop_c;
  logic [15:0]   acc_c;
  logic [CW-1:0] count_c;

  int errors = 0;
  int n_checks = 0;
  int cyc = 0;
  int pop_last = 0;
  int pop_prev = 0;

  // ---------------- clock / reset / multiplier stand-in ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [WP-1:0] mul_pipe [L] = '{default: '0};
  always @(posedge clk) begin
    if (pip_en) begin
      mul_pipe[0] <= op_a * op_b;
      for (int i = 1; i < L; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
  end
  assign prod = mul_pipe[L-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  mac_accumulator #(.WIDTH_P(WP), .WIDTH_ACC(32), .LATENCY(L), .CNT_W(CW), .SATURATE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .pip_en(pip_en), .in_valid(in_valid), .in_last(in_last),
    .prod(prod), .hold(hold_a), .out_valid(valid_a), .out_ready(out_ready),
    .out_acc(acc_a), .out_count(count_a), .out_sat(sat_a), .err_drop(drop_a));

  mac_accumulator #(.WIDTH_P(WP), .WIDTH_ACC(16), .LATENCY(L), .CNT_W(CW), .SATURATE(1)) u_s16 (
    .clk(clk), .rst_n(rst_n), .pip_en(pip_en), .in_valid(in_valid), .in_last(in_last),
    .prod(prod), .hold(hold_b), .out_valid(valid_b), .out_ready(out_ready),
    .out_acc(acc_b), .out_count(count_b), .out_sat(sat_b), .err_drop(drop_b));

  mac_accumulator #(.WIDTH_P(WP), .WIDTH_ACC(16), .LATENCY(L), .CNT_W(CW), .SATURATE(0)) u_w16 (
    .clk(clk), .rst_n(rst_n), .pip_en(pip_en), .in_valid(in_valid), .in_last(in_last),
    .prod(prod), .hold(hold_c), .out_valid(valid_c), .out_ready(out_ready),
    .out_acc(acc_c), .out_count(count_c), .out_sat(sat_c), .err_drop(drop_c));

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0]   a32;
    logic [15:0]   a16s;
    logic [15:0]   a16w;
    logic [CW-1:0] cnt;
    logic          s32;
    logic          s16s;
    logic          s16w;
  } exp_t;

  exp_t exp_q[$];

  longint m32 = 0, ms = 0, mw = 0;
  bit     f32 = 0, fs = 0, fw = 0;
  int     mcnt = 0;
  bit     rand_mode = 0, force_en = 0, drop_next = 0, exp_drop = 0;

  function automatic longint fold(input longint s, input int w, input bit sat, output bit ovf);
    longint mx, mn, r;
    mx  = (longint'(1) <<< (w - 1)) - 1;
    mn  = -mx - 1;
    ovf = (s > mx) || (s < mn);
    if (!ovf)      r = s;
    else if (sat)  r = (s > mx) ? mx : mn;
    else begin
      r = s <<< (64 - w);
      r = r >>> (64 - w);
    end
    return r;
  endfunction

  task automatic model_clear();
    m32 = 0; ms = 0; mw = 0;
    f32 = 0; fs = 0; fw = 0;
    mcnt = 0;
  endtask

  task automatic model_term(input longint p, input bit last);
    bit o;
    m32 = fold(m32 + p, 32, 1'b1, o); f32 |= o;
    ms  = fold(ms + p, 16, 1'b1, o);  fs  |= o;
    mw  = fold(mw + p, 16, 1'b0, o);  fw  |= o;
    mcnt = (mcnt == 255) ? 255 : mcnt + 1;
    if (last) begin
      if (drop_next) begin
        exp_drop  = 1'b1;
        drop_next = 1'b0;
      end else begin
        exp_q.push_back('{a32: 32'(m32), a16s: 16'(ms), a16w: 16'(mw), cnt: CW'(mcnt),
                          s32: f32, s16s: fs, s16w: fw});
      end
      model_clear();
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && valid_a && out_ready) begin
      check("result_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("acc32",   acc_a,          e.a32);
        check("acc16s",  32'(acc_b),     32'(e.a16s));
        check("acc16w",  32'(acc_c),     32'(e.a16w));
        check("count",   32'(count_a),   32'(e.cnt));
        check("sat32",   32'(sat_a),     32'(e.s32));
        check("sat16s",  32'(sat_b),     32'(e.s16s));
        check("sat16w",  32'(sat_c),     32'(e.s16w));
      end
      pop_prev = pop_last;
      pop_last = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents one cycle of stimulus; a wanted advance blocked by hold (or a
  // random stall) is retried so the pair is never lost.
  task automatic present(input longint a, input longint b, input bit v, input bit last,
                         input bit want_en);
    int tries;
    bit adv;
    tries = 0;
    do begin
      if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      adv = want_en && (force_en || !(valid_a && !out_ready));
      if (rand_mode && $urandom_range(0, 3) == 0) adv = 1'b0;
      pip_en   = adv;
      in_valid = v;
      in_last  = last;
      op_a     = WP'(a);
      op_b     = WP'(b);
      if (adv && v) model_term(a * b, last);
      @(posedge clk); #1;
      tries++;
    end while (want_en && !adv && tries < 200);
    if (want_en && !adv) check("advance_budget", 32'(tries), 32'd199);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) present(0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic wait_valid(output int t);
    int n;
    n = 0;
    while (!valid_a && n < 100) begin
      idle(1);
      n++;
    end
    if (!valid_a) check("valid_timeout", 32'(valid_a), 32'd1);
    t = cyc;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, t1;
    rst_n = 1'b0;
    pip_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_acc",   acc_a,        32'd0);
    check("rst_count", 32'(count_a), 32'd0);
    check("rst_sat",   32'(sat_a),   32'd0);
    check("rst_drop",  32'(drop_a),  32'd0);
    check("rst_hold",  32'(hold_a),  32'd0);
    rst_n = 1'b1;
    idle(2);

    // Three-term dot product, latency from the last pair.
    present(5, 3, 1, 0, 1);
    present(7, 2, 1, 0, 1);
    present(15, 1, 1, 1, 1);
    t0 = cyc;
    wait_valid(t1);
    check("lat_basic", 32'(t1 - t0), 32'(L));
    idle(3);

    // Back-to-back single-term dot products.
    present(-5, 3, 1, 1, 1);
    present(-5, -7, 1, 1, 1);
    wait_valid(t1);
    idle(3);
    check("b2b_gap", 32'(pop_last - pop_prev), 32'd1);

    // Four stall cycles mid-stream with junk on the inputs.
    present(1, -1, 1, 0, 1);
    t0 = cyc;
    present(-1, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) present(9, 9, 1, 1, 0);
    present(2, 2, 1, 1, 1);
    wait_valid(t1);
    check("lat_stall", 32'(t1 - t0), 32'(L + 6));
    idle(3);

    // Overflow: saturating and wrapping 16-bit instances diverge.
    present(127, 127, 1, 0, 1);
    present(127, 127, 1, 0, 1);
    present(127, 127, 1, 1, 1);
    wait_valid(t1);
    idle(3);

    // Blocked output register, then a forced second result that must drop.
    out_ready = 1'b0;
    present(2, 3, 1, 1, 1);
    wait_valid(t1);
    check("hold_pending", 32'(hold_a), 32'd1);
    force_en  = 1'b1;
    drop_next = 1'b1;
    present(4, 5, 1, 1, 1);
    idle(L + 1);
    check("err_drop_set", 32'(drop_a), 32'(exp_drop));
    check("kept_acc",     acc_a,       32'd6);
    check("hold_still",   32'(hold_a), 32'd1);
    force_en  = 1'b0;
    out_ready = 1'b1;
    idle(3);
    check("valid_drained", 32'(valid_a), 32'd0);
    check("err_sticky",    32'(drop_a),  32'd1);

    // Reset mid-accumulation discards the partial sum and the sticky flag.
    present(1, 2, 1, 0, 1);
    present(3, 4, 1, 0, 1);
    idle(L);
    rst_n    = 1'b0;
    pip_en   = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    exp_drop = 1'b0;
    check("rst2_drop",  32'(drop_a),  32'(exp_drop));
    check("rst2_valid", 32'(valid_a), 32'd0);
    present(3, 4, 1, 1, 1);
    wait_valid(t1);
    idle(3);
    check("rst2_sat", 32'(sat_a), 32'd0);

    // Random dot products with random stalls and backpressure.
    rand_mode = 1'b1;
    for (int d = 0; d < 12; d++) begin
      int len;
      len = int'($urandom_range(1, 4));
      for (int k = 0; k < len; k++) begin
        present(longint'(int'($urandom_range(0, 200)) - 100),
                longint'(int'($urandom_range(0, 200)) - 100), 1, (k == len - 1), 1);
      end
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    idle(L + 6);
    check("drained",     32'(exp_q.size()), 32'd0);
    check("no_rand_drop", 32'(drop_a),      32'(exp_drop));

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
